// File: rtl/xorchain_pkg.sv
// Shared types and segment-geometry helpers for the xorchain pipeline.
// Optional feature macro: XORCHAIN_PAR_EN (adds the out_par parity output).
package xorchain_pkg;

    typedef enum logic {
        MODE_ADJ = 1'b0,
        MODE_PFX = 1'b1
    } xc_mode_t;

    // Bits resolved per stage: ceil(wd / stages).
    function automatic int seg_w(input int wd, input int stages);
        return (wd + stages - 1) / stages;
    endfunction

    // Lowest bit of segment s. Segments past the top of the word are empty (lo = wd).
    function automatic int seg_lo(input int wd, input int stages, input int s);
        int lo;
        lo = s * seg_w(wd, stages);
        if (lo > wd) begin
            lo = wd;
        end
        return lo;
    endfunction

    // Highest bit of segment s. The last segment is truncated to hold the remainder.
    function automatic int seg_hi(input int wd, input int stages, input int s);
        int hi;
        hi = (s + 1) * seg_w(wd, stages) - 1;
        if (hi > wd - 1) begin
            hi = wd - 1;
        end
        return hi;
    endfunction

endpackage

// File: rtl/xorchain_stage.sv
// One pipeline stage of xorchain_pipe: resolves output bits SEG_LO..SEG_HI from the
// running carry handed over by the previous stage and registers the beat.
// Parity tracking is present only when XORCHAIN_PAR_EN is defined.
module xorchain_stage
    import xorchain_pkg::*;
#(
    parameter int WD     = 8,
    parameter int SEG_LO = 0,
    parameter int SEG_HI = 3
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          src_valid,
    output logic          src_ready,
    input  xc_mode_t      src_mode,
    input  logic [WD-1:0] src_raw,
    input  logic [WD-1:0] src_word,
    input  logic          src_carry,
    input  logic          sink_ready,
    output logic          valid,
    output xc_mode_t      mode,
    output logic [WD-1:0] raw,
    output logic [WD-1:0] word,
    output logic          carry
`ifdef XORCHAIN_PAR_EN
    ,
    input  logic          src_par,
    output logic          par
`endif
);

    logic          valid_reg;
    xc_mode_t      mode_reg;
    logic [WD-1:0] raw_reg;
    logic [WD-1:0] word_reg;
    logic          carry_reg;
    logic [WD-1:0] word_next;
    logic          carry_next;
`ifdef XORCHAIN_PAR_EN
    logic          par_reg;
    logic          par_next;
`endif

    // The stage can take a new beat when it is empty or its current beat leaves now.
    assign src_ready = ~valid_reg | sink_ready;

    // Resolve this stage's segment. For ADJ the carry is the raw bit just below the
    // segment; for PFX it is the prefix XOR of everything below. An empty segment
    // (SEG_LO > SEG_HI) simply forwards word and carry.
    always_comb begin
        logic run;
        word_next = src_word;
        run       = src_carry;
`ifdef XORCHAIN_PAR_EN
        par_next  = src_par;
`endif
        for (int j = 0; j < WD; j++) begin
            if (j >= SEG_LO && j <= SEG_HI) begin
                if (src_mode == MODE_PFX) begin
                    run          = run ^ src_raw[j];
                    word_next[j] = run;
                end else begin
                    word_next[j] = ~run ^ src_raw[j];
                    run          = src_raw[j];
                end
`ifdef XORCHAIN_PAR_EN
                par_next = par_next ^ src_raw[j];
`endif
            end
        end
        carry_next = run;
    end

    // Stage register: valid flag always follows the upstream valid when loading;
    // payload is captured only for real beats so a held output never changes.
    always_ff @(posedge clk) begin
        if (srst) begin
            valid_reg <= 1'b0;
            mode_reg  <= MODE_ADJ;
            raw_reg   <= '0;
            word_reg  <= '0;
            carry_reg <= 1'b0;
`ifdef XORCHAIN_PAR_EN
            par_reg   <= 1'b0;
`endif
        end else if (src_ready) begin
            valid_reg <= src_valid;
            if (src_valid) begin
                mode_reg  <= src_mode;
                raw_reg   <= src_raw;
                word_reg  <= word_next;
                carry_reg <= carry_next;
`ifdef XORCHAIN_PAR_EN
                par_reg   <= par_next;
`endif
            end
        end
    end

    assign valid = valid_reg;
    assign mode  = mode_reg;
    assign raw   = raw_reg;
    assign word  = word_reg;
    assign carry = carry_reg;
`ifdef XORCHAIN_PAR_EN
    assign par   = par_reg;
`endif

endmodule

// File: rtl/xorchain_pipe.sv
// Pipelined adjacent-XOR / prefix-XOR word transform with valid/ready on both sides.
// STAGES register stages each resolve one LSB-first segment; latency is STAGES cycles.
// Optional feature macro: XORCHAIN_PAR_EN (adds out_par, XOR of all input bits of the beat).
module xorchain_pipe
    import xorchain_pkg::*;
#(
    parameter int WD     = 8,
    parameter int STAGES = 2
) (
    input  logic          CLK,
    input  logic          RSTX,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_mode,
    input  logic [WD-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WD-1:0] out_data
`ifdef XORCHAIN_PAR_EN
    ,
    output logic          out_par
`endif
);

    // Element k is the interface between stage k-1 and stage k; element 0 is the input
    // port and element STAGES is the output of the last stage.
    logic          valid_c [0:STAGES];
    logic          ready_c [0:STAGES];
    xc_mode_t      mode_c  [0:STAGES];
    logic [WD-1:0] raw_c   [0:STAGES];
    logic [WD-1:0] word_c  [0:STAGES];
    logic          carry_c [0:STAGES];
`ifdef XORCHAIN_PAR_EN
    logic          par_c   [0:STAGES];
`endif

    // ADJ treats out[0] as ~carry ^ in[0] with carry=1; PFX starts from carry=0.
    assign valid_c[0]      = in_valid;
    assign mode_c[0]       = xc_mode_t'(in_mode);
    assign raw_c[0]        = in_data;
    assign word_c[0]       = '0;
    assign carry_c[0]      = ~in_mode;
    assign ready_c[STAGES] = out_ready;
`ifdef XORCHAIN_PAR_EN
    assign par_c[0]        = 1'b0;
`endif

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        xorchain_stage #(
            .WD     (WD),
            .SEG_LO (seg_lo(WD, STAGES, gi)),
            .SEG_HI (seg_hi(WD, STAGES, gi))
        ) u_stage (
            .clk        (CLK),
            .srst       (RSTX),
            .src_valid  (valid_c[gi]),
            .src_ready  (ready_c[gi]),
            .src_mode   (mode_c[gi]),
            .src_raw    (raw_c[gi]),
            .src_word   (word_c[gi]),
            .src_carry  (carry_c[gi]),
            .sink_ready (ready_c[gi+1]),
            .valid      (valid_c[gi+1]),
            .mode       (mode_c[gi+1]),
            .raw        (raw_c[gi+1]),
            .word       (word_c[gi+1]),
            .carry      (carry_c[gi+1])
`ifdef XORCHAIN_PAR_EN
            ,
            .src_par    (par_c[gi]),
            .par        (par_c[gi+1])
`endif
        );
    end

    // Outputs are forced quiet while reset is held so no stale beat is ever offered.
    assign in_ready  = ready_c[0] & ~RSTX;
    assign out_valid = valid_c[STAGES] & ~RSTX;
    assign out_data  = RSTX ? '0 : word_c[STAGES];
`ifdef XORCHAIN_PAR_EN
    assign out_par   = RSTX ? 1'b0 : par_c[STAGES];
`endif

    // The last stage's side-band fields have no consumer.
    logic unused_tail;
    assign unused_tail = ^{mode_c[STAGES], raw_c[STAGES], carry_c[STAGES]};

endmodule

// File: tb/tb_xorchain_pipe.sv
// Self-checking bench for xorchain_pipe: three instances (8/2, 5/5, 7/3) driven with
// directed and $urandom beats, checked against a word-level reference model.
// Build with XORCHAIN_PAR_EN defined to also check out_par.
module tb_xorchain_pipe;

    typedef struct {
        logic [7:0] data;
        logic       mode;
        int         acc;
    } beat_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic rst;
    int   cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic       iv   [3];
    logic       im   [3];
    logic       ordy [3];
    logic [7:0] idat [3];
    logic       irdy [3];
    logic       ov   [3];
    logic [7:0] od   [3];
    logic       op   [3];
    logic [7:0] od_a;
    logic [4:0] od_b;
    logic [6:0] od_c;

    assign od[0] = od_a;
    assign od[1] = {3'b000, od_b};
    assign od[2] = {1'b0, od_c};
`ifndef XORCHAIN_PAR_EN
    assign op[0] = 1'b0;
    assign op[1] = 1'b0;
    assign op[2] = 1'b0;
`endif

    xorchain_pipe #(.WD(8), .STAGES(2)) u_a (
`ifdef XORCHAIN_PAR_EN
        .out_par   (op[0]),
`endif
        .CLK       (CLK),
        .RSTX      (rst),
        .in_valid  (iv[0]),
        .in_ready  (irdy[0]),
        .in_mode   (im[0]),
        .in_data   (idat[0]),
        .out_valid (ov[0]),
        .out_ready (ordy[0]),
        .out_data  (od_a)
    );

    xorchain_pipe #(.WD(5), .STAGES(5)) u_b (
`ifdef XORCHAIN_PAR_EN
        .out_par   (op[1]),
`endif
        .CLK       (CLK),
        .RSTX      (rst),
        .in_valid  (iv[1]),
        .in_ready  (irdy[1]),
        .in_mode   (im[1]),
        .in_data   (idat[1][4:0]),
        .out_valid (ov[1]),
        .out_ready (ordy[1]),
        .out_data  (od_b)
    );

    xorchain_pipe #(.WD(7), .STAGES(3)) u_c (
`ifdef XORCHAIN_PAR_EN
        .out_par   (op[2]),
`endif
        .CLK       (CLK),
        .RSTX      (rst),
        .in_valid  (iv[2]),
        .in_ready  (irdy[2]),
        .in_mode   (im[2]),
        .in_data   (idat[2][6:0]),
        .out_valid (ov[2]),
        .out_ready (ordy[2]),
        .out_data  (od_c)
    );

    function automatic int wd_of(input int d);
        return (d == 0) ? 8 : (d == 1) ? 5 : 7;
    endfunction

    function automatic int st_of(input int d);
        return (d == 0) ? 2 : (d == 1) ? 5 : 3;
    endfunction

    function automatic logic [7:0] mask_of(input int wd);
        return 8'((1 << wd) - 1);
    endfunction

    // Word-level reference: ADJ keeps bit 0 and XNORs each bit with its lower
    // neighbour; PFX bit j is the parity of bits 0..j.
    function automatic logic [7:0] model(input logic [7:0] d, input logic m, input int wd);
        logic [7:0] r;
        logic [7:0] mask;
        mask = mask_of(wd);
        if (m) begin
            r = '0;
            for (int j = 0; j < wd; j++) begin
                r[j] = ^(d & mask_of(j + 1));
            end
        end else begin
            r = ((~(d ^ (d << 1))) & mask & 8'hFE) | (d & 8'h01);
        end
        return r;
    endfunction

    function automatic logic model_par(input logic [7:0] d, input int wd);
        return ^(d & mask_of(wd));
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (irdy[d] !== 1'b0) begin bad++; $display("FAIL reset_in_ready dut%0d: got %b want 0", d, irdy[d]); end
            total++;
            if (ov[d] !== 1'b0) begin bad++; $display("FAIL reset_out_valid dut%0d: got %b want 0", d, ov[d]); end
            total++;
            if (od[d] !== 8'h00) begin bad++; $display("FAIL reset_out_data dut%0d: got %h want 00", d, od[d]); end
            total++;
            if (op[d] !== 1'b0) begin bad++; $display("FAIL reset_out_par dut%0d: got %b want 0", d, op[d]); end
        end
        @(posedge CLK); #1;
        rst = 1'b0;
        @(negedge CLK);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (irdy[d] !== 1'b1) begin bad++; $display("FAIL release_in_ready dut%0d: got %b want 1", d, irdy[d]); end
            total++;
            if (ov[d] !== 1'b0) begin bad++; $display("FAIL release_out_valid dut%0d: got %b want 0", d, ov[d]); end
        end
    endtask

    task automatic test_directed();
        logic [7:0] tdat [3];
        logic       tmod [3];
        logic [7:0] texp [3];
        tdat = '{8'hFF, 8'h00, 8'hFF};
        tmod = '{1'b1, 1'b0, 1'b0};
        texp = '{8'h55, 8'hFE, 8'hFF};
        ordy[0] = 1'b1;
        for (int e = 0; e < 3; e++) begin
            @(posedge CLK); #1;
            iv[0] = 1'b1; idat[0] = tdat[e]; im[0] = tmod[e];
            @(negedge CLK);
            total++;
            if (irdy[0] !== 1'b1) begin bad++; $display("FAIL directed_accept e%0d: got %b want 1", e, irdy[0]); end
            @(posedge CLK); #1;
            iv[0] = 1'b0; idat[0] = 8'($urandom); im[0] = 1'($urandom);
            for (int k = 1; k <= 3; k++) begin
                @(negedge CLK);
                total++;
                if (ov[0] !== (k == 2)) begin bad++; $display("FAIL directed_valid e%0d k%0d: got %b want %b", e, k, ov[0], (k == 2)); end
                if (k == 2) begin
                    $display("beat dut0 directed in=%h mode=%0d out=%h par=%b", tdat[e], tmod[e], od[0], op[0]);
                    total++;
                    if (od[0] !== texp[e]) begin bad++; $display("FAIL directed_data e%0d: got %h want %h", e, od[0], texp[e]); end
`ifdef XORCHAIN_PAR_EN
                    total++;
                    if (op[0] !== 1'b0) begin bad++; $display("FAIL directed_par e%0d: got %b want 0", e, op[0]); end
`endif
                end
            end
        end
    endtask

    // Random beats into instance d; rand_ready toggles out_ready, alt_mode alternates modes.
    task automatic run_random(input int d, input int n, input bit rand_ready, input bit alt_mode);
        beat_t q[$];
        bit    done;
        int    got;
        int    wd;
        int    st;
        done = 1'b0;
        got  = 0;
        wd   = wd_of(d);
        st   = st_of(d);
        ordy[d] = 1'b1;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    bit acc;
                    acc = 1'b0;
                    @(posedge CLK); #1;
                    iv[d]   = 1'b1;
                    idat[d] = 8'($urandom) & mask_of(wd);
                    im[d]   = alt_mode ? 1'(i % 2) : 1'($urandom);
                    for (int w = 0; w < 200 && !acc; w++) begin
                        @(negedge CLK);
                        if (irdy[d] === 1'b1) begin
                            q.push_back('{idat[d], im[d], cyc});
                            acc = 1'b1;
                        end else begin
                            @(posedge CLK); #1;
                        end
                    end
                    if (!acc) begin
                        total++; bad++;
                        $display("FAIL rand_accept_timeout dut%0d beat%0d: got no in_ready want in_ready", d, i);
                        break;
                    end
                end
                @(posedge CLK); #1;
                iv[d] = 1'b0;
            end
            begin
                while (!done) begin
                    @(posedge CLK); #1;
                    if (rand_ready) ordy[d] = ($urandom_range(0, 3) != 0);
                end
                ordy[d] = 1'b1;
            end
            begin
                logic [7:0] held;
                bit         stalled;
                stalled = 1'b0;
                held    = '0;
                for (int t = 0; t < n * 8 + 50 && got < n; t++) begin
                    @(negedge CLK);
                    if (stalled) begin
                        total++;
                        if (ov[d] !== 1'b1 || od[d] !== held) begin
                            bad++;
                            $display("FAIL rand_hold dut%0d: got valid=%b data=%h want valid=1 data=%h", d, ov[d], od[d], held);
                        end
                    end
                    stalled = 1'b0;
                    if (ov[d] === 1'b1) begin
                        if (ordy[d]) begin
                            beat_t      b;
                            logic [7:0] exp;
                            int         lat;
                            if (q.size() == 0) begin
                                total++; bad++;
                                $display("FAIL rand_spurious dut%0d: got beat %h want none", d, od[d]);
                            end else begin
                                b   = q.pop_front();
                                exp = model(b.data, b.mode, wd);
                                lat = cyc - b.acc;
                                $display("beat dut%0d in=%h mode=%0d out=%h lat=%0d", d, b.data, b.mode, od[d], lat);
                                total++;
                                if (od[d] !== exp) begin bad++; $display("FAIL rand_data dut%0d: got %h want %h", d, od[d], exp); end
                                total++;
                                if (rand_ready ? (lat < st) : (lat != st)) begin
                                    bad++;
                                    $display("FAIL rand_latency dut%0d: got %0d want %0d", d, lat, st);
                                end
`ifdef XORCHAIN_PAR_EN
                                total++;
                                if (op[d] !== model_par(b.data, wd)) begin
                                    bad++;
                                    $display("FAIL rand_par dut%0d: got %b want %b", d, op[d], model_par(b.data, wd));
                                end
`endif
                            end
                            got++;
                        end else begin
                            stalled = 1'b1;
                            held    = od[d];
                        end
                    end
                end
                total++;
                if (got != n) begin bad++; $display("FAIL rand_count dut%0d: got %0d want %0d", d, got, n); end
                done = 1'b1;
            end
        join
        ordy[d] = 1'b1;
    endtask

    task automatic test_stall();
        beat_t      q[$];
        int         nacc;
        bit         seen;
        logic [7:0] first_out;
        logic [7:0] exp;
        nacc = 0;
        seen = 1'b0;
        first_out = '0;
        @(posedge CLK); #1;
        ordy[0] = 1'b0;
        iv[0] = 1'b1; idat[0] = 8'($urandom); im[0] = 1'($urandom);
        for (int k = 0; k < 5; k++) begin
            bit acc;
            acc = 1'b0;
            @(negedge CLK);
            if (irdy[0] === 1'b1) begin
                q.push_back('{idat[0], im[0], cyc});
                nacc++;
                acc = 1'b1;
            end
            if (ov[0] === 1'b1) begin
                if (!seen) begin
                    seen = 1'b1;
                    first_out = od[0];
                    exp = model(q[0].data, q[0].mode, 8);
                    total++;
                    if (od[0] !== exp) begin bad++; $display("FAIL stall_first_data: got %h want %h", od[0], exp); end
                end else begin
                    total++;
                    if (od[0] !== first_out) begin bad++; $display("FAIL stall_stable: got %h want %h", od[0], first_out); end
                end
            end
            @(posedge CLK); #1;
            if (acc) begin idat[0] = 8'($urandom); im[0] = 1'($urandom); end
        end
        @(negedge CLK);
        total++;
        if (nacc != 2) begin bad++; $display("FAIL stall_accepted: got %0d want 2", nacc); end
        total++;
        if (irdy[0] !== 1'b0) begin bad++; $display("FAIL stall_in_ready: got %b want 0", irdy[0]); end
        total++;
        if (!seen || ov[0] !== 1'b1) begin bad++; $display("FAIL stall_out_valid: got %b want 1", ov[0]); end
        @(posedge CLK); #1;
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        for (int t = 0; t < 10 && q.size() > 0; t++) begin
            @(negedge CLK);
            if (ov[0] === 1'b1) begin
                beat_t b;
                b = q.pop_front();
                exp = model(b.data, b.mode, 8);
                $display("beat dut0 drain in=%h mode=%0d out=%h", b.data, b.mode, od[0]);
                total++;
                if (od[0] !== exp) begin bad++; $display("FAIL stall_drain_data: got %h want %h", od[0], exp); end
            end
        end
        total++;
        if (q.size() != 0) begin bad++; $display("FAIL stall_drain_count: got %0d left want 0", q.size()); end
    endtask

    task automatic test_reset_flush();
        ordy[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK); #1;
            iv[0] = 1'b1; idat[0] = 8'($urandom); im[0] = 1'($urandom);
            @(negedge CLK);
            total++;
            if (irdy[0] !== 1'b1) begin bad++; $display("FAIL flush_accept b%0d: got %b want 1", i, irdy[0]); end
        end
        @(posedge CLK); #1;
        iv[0] = 1'b0;
        rst = 1'b1;
        @(negedge CLK);
        total++;
        if (ov[0] !== 1'b0) begin bad++; $display("FAIL flush_valid_in_reset: got %b want 0", ov[0]); end
        @(posedge CLK); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            total++;
            if (ov[0] !== 1'b0) begin bad++; $display("FAIL flush_stale k%0d: got valid %b data %h want valid 0", k, ov[0], od[0]); end
        end
        @(posedge CLK); #1;
        iv[0] = 1'b1; idat[0] = 8'h01; im[0] = 1'b1;
        @(negedge CLK);
        total++;
        if (irdy[0] !== 1'b1) begin bad++; $display("FAIL flush_post_accept: got %b want 1", irdy[0]); end
        @(posedge CLK); #1;
        iv[0] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLK);
            total++;
            if (ov[0] !== (k == 2)) begin bad++; $display("FAIL flush_post_valid k%0d: got %b want %b", k, ov[0], (k == 2)); end
            if (k == 2) begin
                $display("beat dut0 post-reset in=01 mode=1 out=%h", od[0]);
                total++;
                if (od[0] !== 8'hFF) begin bad++; $display("FAIL flush_post_data: got %h want ff", od[0]); end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0; im[d] = 1'b0; idat[d] = '0; ordy[d] = 1'b1;
        end
        test_reset();
        test_directed();
        run_random(0, 16, 1'b0, 1'b1);
        test_stall();
        test_reset_flush();
        run_random(0, 24, 1'b1, 1'b0);
        run_random(1, 24, 1'b1, 1'b0);
        run_random(1, 12, 1'b0, 1'b0);
        run_random(2, 24, 1'b1, 1'b0);
        run_random(2, 12, 1'b0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
